uart_rx: RTL

//  Serial-to-parallel UART receiver; pairs with uart_tx as the receive end of the same link.

---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : serial-to-parallel UART receiver (receive end of a uart_tx link)
//
// Frame: idle-high line, one low start bit, `length` data bits LSB first,
// optional even-parity bit, one high stop bit.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> one even-parity bit follows the data bits, adds parity_error
//   undefined -> no parity bit, no parity_error port
//
// Parameters
//   length        data bits per frame
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//
// Ports
//   clk                     in   system clock, all logic on posedge
//   rstn                    in   asynchronous active-low reset
//   data_receiver           in   serial line, idle high, asynchronous to clk
//   data_received_register  out  data of the last good frame
//   data_received_signal    out  1-cycle pulse, new data in the register
//   framing_error           out  1-cycle pulse, stop bit sampled low
//   parity_error            out  1-cycle pulse, parity mismatch (macro only)
//   current_state           out  FSM state for debug
//
// Output handshake: data_received_signal is a valid-only strobe. There is no
// ready back-pressure; the consumer must take data_received_register in the
// cycle the strobe is high, and a later good frame overwrites it. The error
// strobes and the data strobe are mutually exclusive.
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int length       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              data_receiver,
    output logic [length-1:0] data_received_register,
    output logic              data_received_signal,
    output logic              framing_error,
`ifdef UART_RX_PARITY_EN
    output logic              parity_error,
`endif
    output logic [1:0]        current_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Bits sampled in the DATA state: data bits, plus the parity bit if enabled.
`ifdef UART_RX_PARITY_EN
    localparam int SAMPLE_BITS = length + 1;
`else
    localparam int SAMPLE_BITS = length;
`endif

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(SAMPLE_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SAMPLE_BITS - 1);
    localparam logic [BW-1:0] BIT_DATA = BW'(length);

    logic              rx_s;
    logic              rx_d;
    logic [1:0]        state;
    logic [CW-1:0]     clk_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [length-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
    logic              parity_bit;
`endif

    assign current_state = state;

    // Two-flop synchronizer; rx_d is the older sample so a 1->0 transition
    // shows up as rx_d=1, rx_s=0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_s <= data_receiver;
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                  <= ST_IDLE;
            clk_cnt                <= '0;
            bit_cnt                <= '0;
            shift_reg              <= '0;
            data_received_register <= '0;
            data_received_signal   <= 1'b0;
            framing_error          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit             <= 1'b0;
            parity_error           <= 1'b0;
`endif
        end else begin
            data_received_signal <= 1'b0;
            framing_error        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error         <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    // Edge-triggered start: a line stuck low never starts a frame.
                    if (rx_d && !rx_s) begin
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        // Re-check mid start bit; high here means it was a glitch.
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_cnt < BIT_DATA) begin
                            // Right shift: first (LSB) bit ends up in [0].
                            shift_reg <= {rx_s, shift_reg[length-1:1]};
                        end
`ifdef UART_RX_PARITY_EN
                        else begin
                            parity_bit <= rx_s;
                        end
`endif
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        state   <= ST_IDLE;
                        if (!rx_s) begin
                            framing_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if ((^shift_reg) ^ parity_bit) begin
                            // Even parity: data ones plus parity bit must be even.
                            parity_error <= 1'b1;
`endif
                        end else begin
                            data_received_register <= shift_reg;
                            data_received_signal   <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
